pipeline_run_ctrl: RTL and testbench
====================================

// Module: pipeline_run_ctrl
// PURPOSE
// Run/step/halt sequencer for the 5-stage MIPS pipeline. Drives the global
// enable of every pipeline register (including the registered sign-extend
// stage) and the PC enable. Accepts RUN/STEP/STOP commands from the debug unit.
// Detects the HALT opcode at fetch, drains in-flight instructions, then parks.
// PARAMETERS
// CNT_W        32         width of cycle_cnt
// DRAIN_CYCLES 4          enabled cycles after HALT fetch (pipeline depth - 1), >=1
// HALT_OPCODE  6'b111111  instr[31:26] value that terminates execution
// PORTS
// clk        in   1      clock, all logic on rising edge
// reset      in   1      synchronous, active-high
// cmd_valid  in   1      command strobe from debug unit
// cmd_code   in   2      00 NOP, 01 RUN, 10 STEP, 11 STOP
// cmd_ready  out  1      command accepted when cmd_valid & cmd_ready
// if_instr   in   32     instruction currently output by instruction memory
// pipe_en    out  1      enable for all pipeline registers
// fetch_en   out  1      PC write enable
// busy       out  1      1 in RUN, STEP, DRAIN
// done       out  1      one-cycle pulse on entry to HALTED
// cycle_cnt  out  CNT_W  count of cycles with pipe_en=1
// state      out  3      IDLE=0 RUN=1 STEP=2 DRAIN=3 HALTED=4
// BEHAVIOUR
// - Reset: state=IDLE, drain counter=0, cycle_cnt=0, done=0; hence pipe_en=0,
//   fetch_en=0, busy=0, cmd_ready=1. Reset wins over everything, any state.
// - Moore outputs decoded from registered state:
//   pipe_en=1 in RUN/STEP/DRAIN; fetch_en=1 in RUN/STEP; cmd_ready=1 in IDLE/RUN.
// - Command accepted at edge N -> new state (and pipe_en) visible in cycle N+1.
// - IDLE: RUN->RUN; STEP->STEP; STOP/NOP ignored (stay IDLE).
// - RUN: STOP->IDLE; RUN/STEP/NOP ignored. Pipeline advances every cycle.
// - STEP: exactly one enabled cycle, then IDLE. No commands accepted.
// - halt_hit = fetch_en & (if_instr[31:26]==HALT_OPCODE). In RUN or STEP,
//   halt_hit at an edge -> DRAIN, drain counter loaded with DRAIN_CYCLES.
//   halt_hit has priority over a simultaneous STOP (STOP consumed, discarded)
//   and over STEP's return to IDLE.
// - DRAIN: pipe_en=1, fetch_en=0 (PC frozen on HALT); counter decrements each
//   cycle; edge where counter==1 -> HALTED. Exactly DRAIN_CYCLES drain cycles.
//   DRAIN ignores commands (cmd_ready=0), runs to completion uninterrupted.
// - HALTED: all enables 0, cmd_ready=0; left only by reset.
// - done registered: 1 during first HALTED cycle only.
// - cycle_cnt += 1 on every edge where pipe_en=1; wraps modulo 2^CNT_W;
//   holds in IDLE/HALTED; cleared only by reset.
// - Unused state encodings (5-7) -> IDLE next cycle, outputs as IDLE.
// TESTING
// 1 Reset, RUN cmd, no HALT for 10 cycles -> pipe_en=fetch_en=1 from cycle
//   after accept, cycle_cnt=10, state=1.
// 2 From IDLE, three STEP cmds spaced 3 cycles -> exactly three 1-cycle
//   pipe_en pulses, cycle_cnt=3, state back to 0 after each.
// 3 RUN, HALT opcode on if_instr at cycle 5 -> fetch_en drops next cycle,
//   pipe_en high 4 more cycles, done pulse once, state=4, cycle_cnt=10.
// 4 RUN, STOP and HALT opcode in same cycle -> DRAIN taken, STOP discarded,
//   ends HALTED; STOP/RUN sent during DRAIN/HALTED -> cmd_ready=0, no effect.
// 5 STEP onto HALT opcode -> DRAIN 4 cycles then HALTED with done pulse.
// 6 Reset asserted mid-DRAIN and in HALTED -> next cycle state=0, cycle_cnt=0,
//   all enables 0; CNT_W=4 with 17 RUN cycles -> cycle_cnt wraps to 1.

Source files
------------

// File: rtl/pipeline_run_ctrl.sv
// pipeline_run_ctrl
// Run/step/halt sequencer for the 5-stage pipeline. Produces the global
// pipeline-register enable and the PC enable from debug-unit commands, and
// parks the machine after the HALT opcode has been fetched and drained.
module pipeline_run_ctrl #(
  parameter int          CNT_W        = 32,
  parameter int          DRAIN_CYCLES = 4,
  parameter logic [5:0]  HALT_OPCODE  = 6'b111111
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  input  logic [1:0]       cmd_code,
  output logic             cmd_ready,
  input  logic [31:0]      if_instr,
  output logic             pipe_en,
  output logic             fetch_en,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [2:0]       state
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RUN    = 3'd1,
    STEP   = 3'd2,
    DRAIN  = 3'd3,
    HALTED = 3'd4
  } state_t;

  localparam logic [1:0] CMD_RUN  = 2'b01;
  localparam logic [1:0] CMD_STEP = 2'b10;
  localparam logic [1:0] CMD_STOP = 2'b11;

  // Drain counter only has to hold DRAIN_CYCLES down to 1.
  localparam int                DW         = $clog2(DRAIN_CYCLES + 1);
  localparam logic [DW-1:0]     DRAIN_LOAD = DW'(DRAIN_CYCLES);
  localparam logic [DW-1:0]     DRAIN_LAST = DW'(1);

  state_t           state_reg;
  state_t           state_dec;
  logic [DW-1:0]    drain_cnt_reg;
  logic [CNT_W-1:0] cycle_cnt_reg;
  logic             done_reg;
  logic             halt_hit;
  logic             cmd_acc;
  logic             unused_instr_bits;

  // Illegal encodings behave exactly like IDLE until the next edge clears them.
  assign state_dec = (state_reg > HALTED) ? IDLE : state_reg;

  assign pipe_en   = (state_dec == RUN) || (state_dec == STEP) || (state_dec == DRAIN);
  assign fetch_en  = (state_dec == RUN) || (state_dec == STEP);
  assign busy      = pipe_en;
  assign cmd_ready = (state_dec == IDLE) || (state_dec == RUN);
  assign state     = state_dec;
  assign done      = done_reg;
  assign cycle_cnt = cycle_cnt_reg;

  // Only the opcode field matters; HALT is only recognised while the PC advances.
  assign halt_hit          = fetch_en && (if_instr[31:26] == HALT_OPCODE);
  assign cmd_acc           = cmd_valid && cmd_ready;
  assign unused_instr_bits = ^if_instr[25:0];

  // Sequencer state, drain countdown, done pulse and enabled-cycle counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      drain_cnt_reg <= '0;
      cycle_cnt_reg <= '0;
      done_reg      <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      if (pipe_en) begin
        cycle_cnt_reg <= cycle_cnt_reg + CNT_W'(1);
      end
      case (state_reg)
        IDLE: begin
          if (cmd_acc && cmd_code == CMD_RUN) begin
            state_reg <= RUN;
          end else if (cmd_acc && cmd_code == CMD_STEP) begin
            state_reg <= STEP;
          end
        end
        RUN: begin
          // HALT wins over a STOP arriving in the same cycle.
          if (halt_hit) begin
            state_reg     <= DRAIN;
            drain_cnt_reg <= DRAIN_LOAD;
          end else if (cmd_acc && cmd_code == CMD_STOP) begin
            state_reg <= IDLE;
          end
        end
        STEP: begin
          if (halt_hit) begin
            state_reg     <= DRAIN;
            drain_cnt_reg <= DRAIN_LOAD;
          end else begin
            state_reg <= IDLE;
          end
        end
        DRAIN: begin
          if (drain_cnt_reg == DRAIN_LAST) begin
            state_reg <= HALTED;
            done_reg  <= 1'b1;
          end else begin
            drain_cnt_reg <= drain_cnt_reg - DRAIN_LAST;
          end
        end
        HALTED: begin
          state_reg <= HALTED;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pipeline_run_ctrl.sv
// Bench for pipeline_run_ctrl: directed scenarios followed by random commands,
// all compared each cycle against a behavioural model. A second instance with
// a 4-bit counter shares the stimulus to exercise counter wrap.
module tb_pipeline_run_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic [1:0]  cmd_code;
  logic [31:0] if_instr;

  logic        cmd_ready, pipe_en, fetch_en, busy, done;
  logic [31:0] cycle_cnt;
  logic [2:0]  state;

  logic        s_cmd_ready, s_pipe_en, s_fetch_en, s_busy, s_done;
  logic [3:0]  s_cycle_cnt;
  logic [2:0]  s_state;

  int checks = 0;
  int errors = 0;

  // Model: spec-level view of the sequencer
  int          m_st;
  int          m_drain;
  int unsigned m_cnt;
  bit          m_done;

  always #5 clk = ~clk;

  pipeline_run_ctrl #(.CNT_W(32), .DRAIN_CYCLES(4), .HALT_OPCODE(6'b111111)) u_dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_code(cmd_code),
    .cmd_ready(cmd_ready), .if_instr(if_instr), .pipe_en(pipe_en),
    .fetch_en(fetch_en), .busy(busy), .done(done), .cycle_cnt(cycle_cnt),
    .state(state)
  );

  pipeline_run_ctrl #(.CNT_W(4), .DRAIN_CYCLES(4), .HALT_OPCODE(6'b111111)) u_dut4 (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_code(cmd_code),
    .cmd_ready(s_cmd_ready), .if_instr(if_instr), .pipe_en(s_pipe_en),
    .fetch_en(s_fetch_en), .busy(s_busy), .done(s_done), .cycle_cnt(s_cycle_cnt),
    .state(s_state)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit m_pipe();
    return (m_st == 1) || (m_st == 2) || (m_st == 3);
  endfunction

  function automatic bit m_fetch();
    return (m_st == 1) || (m_st == 2);
  endfunction

  function automatic bit m_ready();
    return (m_st == 0) || (m_st == 1);
  endfunction

  // Advance the model by one clock edge with the given inputs.
  task automatic model_step(input bit rst, input bit v, input bit [1:0] code, input bit [31:0] instr);
    bit acc, halt;
    if (rst) begin
      m_st = 0; m_drain = 0; m_cnt = 0; m_done = 0;
      return;
    end
    acc    = v && m_ready();
    halt   = m_fetch() && (instr[31:26] == 6'h3f);
    m_done = (m_st == 3) && (m_drain == 1);
    if (m_pipe()) m_cnt = m_cnt + 1;
    case (m_st)
      0: if (acc && code == 2'b01) m_st = 1;
         else if (acc && code == 2'b10) m_st = 2;
      1: if (halt) begin m_st = 3; m_drain = 4; end
         else if (acc && code == 2'b11) m_st = 0;
      2: if (halt) begin m_st = 3; m_drain = 4; end
         else m_st = 0;
      3: if (m_drain == 1) m_st = 4;
         else m_drain = m_drain - 1;
      default: m_st = 4;
    endcase
  endtask

  task automatic compare_all();
    check("state",      32'(state),       32'(m_st));
    check("pipe_en",    32'(pipe_en),     32'(m_pipe()));
    check("fetch_en",   32'(fetch_en),    32'(m_fetch()));
    check("busy",       32'(busy),        32'(m_pipe()));
    check("cmd_ready",  32'(cmd_ready),   32'(m_ready()));
    check("done",       32'(done),        32'(m_done));
    check("cycle_cnt",  cycle_cnt,        m_cnt);
    check("cnt4",       32'(s_cycle_cnt), 32'(m_cnt % 16));
    check("state4",     32'(s_state),     32'(m_st));
  endtask

  // Drive one cycle of inputs from a negedge, then compare at the next negedge.
  task automatic cycle(input bit rst, input bit v, input bit [1:0] code, input bit [31:0] instr);
    reset = rst; cmd_valid = v; cmd_code = code; if_instr = instr;
    model_step(rst, v, code, instr);
    @(negedge clk);
    compare_all();
    $display("cyc rst=%0b v=%0b code=%0d op=%0h -> state=%0d pe=%0b fe=%0b done=%0b cnt=%0d",
             rst, v, code, instr[31:26], state, pipe_en, fetch_en, done, cycle_cnt);
  endtask

  function automatic bit [31:0] plain_instr();
    bit [5:0] op;
    op = 6'($urandom_range(0, 62));
    return {op, 26'($urandom)};
  endfunction

  function automatic bit [31:0] halt_instr();
    return {6'h3f, 26'($urandom)};
  endfunction

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; cmd_code = 2'b00; if_instr = 32'h0;
    @(negedge clk);
    @(negedge clk);
    m_st = 0; m_drain = 0; m_cnt = 0; m_done = 0;

    // 1: RUN for 10 cycles without HALT
    cycle(1, 0, 2'b00, 32'h0);
    cycle(0, 1, 2'b01, plain_instr());
    for (int i = 0; i < 10; i++) cycle(0, 0, 2'b00, plain_instr());
    check("t1_cnt", cycle_cnt, 32'd10);
    check("t1_state", 32'(state), 32'd1);

    // 2: three STEPs spaced three cycles apart
    cycle(1, 0, 2'b00, 32'h0);
    for (int i = 0; i < 3; i++) begin
      cycle(0, 1, 2'b10, plain_instr());
      check("t2_pulse", 32'(pipe_en), 32'd1);
      cycle(0, 0, 2'b00, plain_instr());
      check("t2_back", 32'(state), 32'd0);
      cycle(0, 0, 2'b00, plain_instr());
    end
    check("t2_cnt", cycle_cnt, 32'd3);

    // 3: HALT fetched during RUN, then drain
    cycle(1, 0, 2'b00, 32'h0);
    cycle(0, 1, 2'b01, plain_instr());
    for (int i = 0; i < 5; i++) cycle(0, 0, 2'b00, plain_instr());
    cycle(0, 0, 2'b00, halt_instr());
    check("t3_fetch_off", 32'(fetch_en), 32'd0);
    for (int i = 0; i < 4; i++) cycle(0, 0, 2'b00, plain_instr());
    check("t3_state", 32'(state), 32'd4);
    check("t3_done", 32'(done), 32'd1);
    check("t3_cnt", cycle_cnt, 32'd10);
    cycle(0, 0, 2'b00, plain_instr());
    check("t3_done_once", 32'(done), 32'd0);

    // 4: STOP together with HALT, commands ignored during DRAIN/HALTED
    cycle(1, 0, 2'b00, 32'h0);
    cycle(0, 1, 2'b01, plain_instr());
    cycle(0, 0, 2'b00, plain_instr());
    cycle(0, 1, 2'b11, halt_instr());
    check("t4_drain", 32'(state), 32'd3);
    for (int i = 0; i < 4; i++) cycle(0, 1, (i % 2 == 0) ? 2'b11 : 2'b01, plain_instr());
    for (int i = 0; i < 3; i++) cycle(0, 1, 2'b01, plain_instr());
    check("t4_parked", 32'(state), 32'd4);

    // 5: STEP onto HALT
    cycle(1, 0, 2'b00, 32'h0);
    cycle(0, 1, 2'b10, plain_instr());
    cycle(0, 0, 2'b00, halt_instr());
    for (int i = 0; i < 4; i++) cycle(0, 0, 2'b00, plain_instr());
    check("t5_state", 32'(state), 32'd4);
    check("t5_done", 32'(done), 32'd1);

    // 6: reset mid-DRAIN and in HALTED, then 4-bit wrap
    cycle(1, 0, 2'b00, 32'h0);
    cycle(0, 1, 2'b01, plain_instr());
    cycle(0, 0, 2'b00, halt_instr());
    cycle(0, 0, 2'b00, plain_instr());
    cycle(1, 0, 2'b00, plain_instr());
    check("t6_rst_drain", 32'(state), 32'd0);
    cycle(0, 1, 2'b01, halt_instr());
    cycle(0, 0, 2'b00, halt_instr());
    for (int i = 0; i < 5; i++) cycle(0, 0, 2'b00, plain_instr());
    cycle(1, 1, 2'b01, plain_instr());
    check("t6_rst_halted", cycle_cnt, 32'd0);
    cycle(0, 1, 2'b01, plain_instr());
    for (int i = 0; i < 17; i++) cycle(0, 0, 2'b00, plain_instr());
    check("t6_wrap", 32'(s_cycle_cnt), 32'd1);

    // Random phase
    cycle(1, 0, 2'b00, 32'h0);
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 39) == 0), 1'($urandom), 2'($urandom),
            ($urandom_range(0, 14) == 0) ? halt_instr() : plain_instr());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
